// File: rtl/chacha_block_ctrl.sv
// ChaCha20 block sequencer: gathers 16 input words, starts the core with init/next,
// captures its result and streams 16 output words back to the host side.
module chacha_block_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [255:0]     key,
  input  logic [63:0]      iv,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [255:0]     core_key,
  output logic [63:0]      core_iv,
  output logic             core_init,
  output logic             core_next,
  output logic [511:0]     core_data_in,
  input  logic             core_ready,
  input  logic [511:0]     core_data_out,
  input  logic             core_data_out_valid
);

  // state | meaning
  // IDLE  | waiting for start
  // FILL  | accepting the 16 input words of a block
  // START | one-cycle core_init (first block) or core_next pulse
  // WAIT  | waiting for the core result, timeout running
  // DRAIN | streaming the 16 captured output words
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_START, ST_WAIT, ST_DRAIN, ST_DONE
  } state_t;

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic             wait_first;
  logic [3:0]       word_idx;
  logic [CNT_W-1:0] blk_cnt;
  logic [CNT_W-1:0] nb_q;
  logic [511:0]     out_buf;
  logic [8:0]       word_lsb;
  logic             capture;
  logic             timeout;
  logic             last_blk;

  // word 0 is the MSW: bits [511-32*i -: 32] start at 32*(15-i)
  assign word_lsb = {~word_idx, 5'd0};
  assign out_data = out_buf[word_lsb +: 32];
  assign capture  = (state == ST_WAIT) && !wait_first && core_data_out_valid;
  assign timeout  = (state == ST_WAIT) && !capture && (tmr == '0);
  assign last_blk = (blk_cnt == nb_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    core_init = 1'b0;
    core_next = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (num_blocks == '0) ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid && (word_idx == 4'd15)) state_nxt = ST_START;
      end
      ST_START: begin
        if (core_ready) begin
          core_init = (blk_cnt == '0);
          core_next = (blk_cnt != '0);
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (capture) begin
          state_nxt = ST_DRAIN;
        end else if (timeout) begin
          error     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (word_idx == 4'd15)) state_nxt = last_blk ? ST_DONE : ST_FILL;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      core_key     <= '0;
      core_iv      <= '0;
      core_data_in <= '0;
      out_buf      <= '0;
      nb_q         <= '0;
      blk_cnt      <= '0;
      word_idx     <= '0;
      tmr          <= '0;
      wait_first   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (num_blocks != '0)) begin
            core_key <= key;
            core_iv  <= iv;
            nb_q     <= num_blocks;
            blk_cnt  <= '0;
            word_idx <= '0;
          end
        end
        ST_FILL: begin
          if (in_valid) begin
            core_data_in[word_lsb +: 32] <= in_data;
            word_idx                     <= word_idx + 4'd1;
          end
        end
        ST_START: begin
          tmr        <= TMR_W'(TIMEOUT_CYCLES - 1);
          wait_first <= 1'b1;
        end
        ST_WAIT: begin
          // the first WAIT cycle may still see the previous block's valid
          wait_first <= 1'b0;
          if (capture)         out_buf <= core_data_out;
          else if (tmr != '0)  tmr     <= tmr - TMR_W'(1);
        end
        ST_DRAIN: begin
          if (out_ready) begin
            word_idx <= word_idx + 4'd1;
            if ((word_idx == 4'd15) && !last_blk) blk_cnt <= blk_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
